fan_line_packer: RTL and testbench
==================================

FAN_LINE_PACKER -- requirements
Module: fan_line_packer

Interface
REQ-001 SHALL have parameter DW_DATA, default 8, width of one product value.
REQ-002 SHALL have parameter DW_ROW, default 4, width of the output-row tag.
REQ-003 SHALL have parameter DW_CTRL, default 4, width of the per-lane control field.
REQ-004 SHALL have parameter DW_LINE, default DW_DATA+DW_ROW+DW_CTRL, width of one lane.
REQ-005 SHALL have parameter NUM_IN, default 2, lanes per line (legal range 2..8).
REQ-006 SHALL have port clk  input  1  sole clock; every register is rising-edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
REQ-008 SHALL have port in_valid  input  1  upstream element present.
REQ-009 SHALL have port in_ready  output  1  element accepted this cycle when in_valid and in_ready are both high.
REQ-010 SHALL have port in_data  input  DW_DATA  product value.
REQ-011 SHALL have port in_row  input  DW_ROW  destination row tag.
REQ-012 SHALL have port in_last  input  1  element is the last of its tile.
REQ-013 SHALL have port out_valid  output  1  line present at out.
REQ-014 SHALL have port out_ready  input  1  line consumed when out_valid and out_ready are both high.
REQ-015 SHALL have port out  output  NUM_IN*DW_LINE  packed line; lane i at bits [(i+1)*DW_LINE-1 : i*DW_LINE].
REQ-016 SHALL have port line_cnt  output  16  count of lines consumed downstream.

Function
REQ-017 Lane format SHALL be {ctrl, row, data}, with ctrl in the MSBs and data in the LSBs.
REQ-018 ctrl[3] SHALL be lane-valid, ctrl[2] SHALL be merge-with-lane-i+1, ctrl[1] SHALL be tile-end, and ctrl[0] SHALL be 0.
REQ-019 Accepted elements SHALL fill the fill buffer in lane order 0..NUM_IN-1, tracked by fill counter cnt (0..NUM_IN).
REQ-020 A line SHALL be sealed when cnt reaches NUM_IN, or when an element with in_last=1 is accepted.
REQ-021 Unused lanes of a sealed line SHALL be all-zero.
REQ-022 A line with zero valid lanes SHALL never be emitted.
REQ-023 ctrl[2] of lane i SHALL be 1 only if lanes i and i+1 are both valid and their rows are equal.
REQ-024 ctrl[2] of lane NUM_IN-1 SHALL always be 0.
REQ-025 ctrl[1] SHALL be 1 only on the lane holding the in_last element.
REQ-026 Sealing SHALL copy the fill buffer into the output register and clear cnt to 0 in the same cycle.
REQ-027 out_valid SHALL rise in cycle t+1 when the sealing element is accepted in cycle t.
REQ-028 The output register SHALL hold out stable while out_valid=1 and out_ready=0.
REQ-029 The block SHALL track output-register state OUT_EMPTY / OUT_FULL.
REQ-030 OUT_EMPTY SHALL go to OUT_FULL on seal.
REQ-031 OUT_FULL SHALL go to OUT_EMPTY on consume, unless a seal occurs in the same cycle, in which case it SHALL stay OUT_FULL with the new line loaded.
REQ-032 in_ready SHALL be low only when cnt=NUM_IN-1, the output register is OUT_FULL and out_ready=0, or when the fill buffer cannot otherwise be sealed.
REQ-033 in_ready SHALL depend combinationally on out_ready only.
REQ-034 When in_ready=1 and the line is sealed, a consume and a seal in the same cycle SHALL lose no data.
REQ-035 An element with in_last=1 arriving when cnt=NUM_IN-1 SHALL seal a full line with ctrl[1] set on lane NUM_IN-1.
REQ-036 line_cnt SHALL increment by 1 on each consume and wrap from 0xFFFF to 0.
REQ-037 Inputs offered while in_ready=0 SHALL NOT be sampled.

Reset
REQ-038 While rst=0: cnt=0, fill buffer=0, OUT_EMPTY, out_valid=0, out=0, line_cnt=0, in_ready=1.
REQ-039 rst=0 asserted mid-line SHALL discard any partially filled line and any unconsumed line.
REQ-040 Elements SHALL be accepted from the first rising edge after rst returns to 1.

Verification (NUM_IN=2, out_ready=1 unless stated)
REQ-041 Elements (row0,0x01), (row0,0x02), no last -> next cycle out=0x8002_C001, out_valid=1.
REQ-042 Elements (row0,0x01), (row1,0x02) with last on the second -> out=0xA102_8001.
REQ-043 Single element (row0,0x05) with last=1 -> out=0x0000_A005; no further line is emitted.
REQ-044 out_ready=0, stream 4 elements -> in_ready drops after the 3rd acceptance; raising out_ready drains 2 lines in order with no loss; line_cnt=2.
REQ-045 rst=0 pulsed after 1 element accepted -> all outputs return to reset values; the next 2 elements form a fresh line.
REQ-046 Force line_cnt to 0xFFFF, consume one line -> line_cnt=0x0000.

Source files
------------

// File: rtl/fan_line_packer_if.sv
// fan_line_packer_if: element stream in, packed line stream out.
//   in_valid/in_ready  : element handshake (master drives in_valid)
//   in_data/in_row     : product value and destination row tag
//   in_last            : element closes its tile
//   out_valid/out_ready: line handshake (slave drives out_valid)
//   out                : packed line, lane i at [(i+1)*DW_LINE-1 : i*DW_LINE]
interface fan_line_packer_if #(
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_LINE = 16,
    parameter int NUM_IN  = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DW_DATA-1:0]        in_data;
    logic [DW_ROW-1:0]         in_row;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_IN*DW_LINE-1:0] out;

    modport master (
        output in_valid, in_data, in_row, in_last, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in_data, in_row, in_last, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fan_line_packer.sv
// fan_line_packer: packs a stream of (row, data) elements into lines of
// NUM_IN lanes. Each lane is {ctrl, row, data}; ctrl[3]=lane valid,
// ctrl[2]=merge with next lane (same row), ctrl[1]=tile end, ctrl[0]=0.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   bus      : element input / line output handshakes (slave side)
//   line_cnt : number of lines consumed downstream, wraps at 16 bits
module fan_line_packer #(
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    parameter int NUM_IN  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fan_line_packer_if.slave     bus,
    output logic [15:0]          line_cnt
);
    localparam int CW = $clog2(NUM_IN + 1);
    // cnt == NUM_IN marks a tile-end line sealed while the output register
    // was still occupied; it waits in the fill buffer for the next free slot.
    localparam logic [CW-1:0] CNT_SEALED = CW'(NUM_IN);
    localparam logic [CW-1:0] CNT_LAST   = CW'(NUM_IN - 1);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
    out_state_t state, state_nxt;

    logic [CW-1:0]                  cnt, cnt_nxt;
    logic [NUM_IN-1:0]              f_valid, f_last, m_valid, m_last, merge;
    logic [NUM_IN-1:0][DW_ROW-1:0]  f_row, m_row;
    logic [NUM_IN-1:0][DW_DATA-1:0] f_data, m_data;
    logic [NUM_IN*DW_LINE-1:0]      out_q, line;
    logic [DW_LINE-1:0]             lane;
    logic                           full, out_free, accept, seal_in, load;

    assign full          = (state == OUT_FULL);
    assign bus.out_valid = full;
    assign bus.out       = out_q;

    always_comb begin
        out_free     = !full || bus.out_ready;
        bus.in_ready = (cnt != CNT_SEALED) &&
                       !((cnt == CNT_LAST) && full && !bus.out_ready);
        accept       = bus.in_valid && bus.in_ready;
        seal_in      = accept && (bus.in_last || (cnt == CNT_LAST));
        load         = out_free && (seal_in || (cnt == CNT_SEALED));

        // fill buffer with the accepted element merged into lane cnt
        m_valid = f_valid;
        m_last  = f_last;
        m_row   = f_row;
        m_data  = f_data;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (accept && (cnt == CW'(i))) begin
                m_valid[i] = 1'b1;
                m_last[i]  = bus.in_last;
                m_row[i]   = bus.in_row;
                m_data[i]  = bus.in_data;
            end
        end

        merge = '0;
        for (int unsigned i = 0; i < NUM_IN - 1; i++) begin
            merge[i] = m_valid[i] && m_valid[i+1] && (m_row[i] == m_row[i+1]);
        end

        line = '0;
        lane = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            lane                          = '0;
            lane[DW_DATA-1:0]             = m_data[i];
            lane[DW_DATA +: DW_ROW]       = m_row[i];
            lane[DW_DATA + DW_ROW + 3]    = m_valid[i];
            lane[DW_DATA + DW_ROW + 2]    = merge[i];
            lane[DW_DATA + DW_ROW + 1]    = m_last[i];
            line[i*DW_LINE +: DW_LINE]    = lane;
        end

        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = '0;
        end else if (accept) begin
            cnt_nxt = seal_in ? CNT_SEALED : cnt + CW'(1);
        end

        state_nxt = state;
        if (load) begin
            state_nxt = OUT_FULL;
        end else if (full && bus.out_ready) begin
            state_nxt = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            f_valid  <= '0;
            f_last   <= '0;
            f_row    <= '0;
            f_data   <= '0;
            out_q    <= '0;
            line_cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (load) begin
                f_valid <= '0;
                f_last  <= '0;
                f_row   <= '0;
                f_data  <= '0;
                out_q   <= line;
            end else if (accept) begin
                f_valid <= m_valid;
                f_last  <= m_last;
                f_row   <= m_row;
                f_data  <= m_data;
            end
            if (full && bus.out_ready) begin
                line_cnt <= line_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fan_line_packer.sv
// Testbench for fan_line_packer (NUM_IN=2, default widths).
module tb_fan_line_packer;
    localparam int NUM_IN = 2;
    localparam int BUDGET = 50;

    logic        clk;
    logic        rst;
    logic [15:0] line_cnt;

    fan_line_packer_if #(.DW_DATA(8), .DW_ROW(4), .DW_LINE(16), .NUM_IN(NUM_IN)) bus ();

    fan_line_packer #(.DW_DATA(8), .DW_ROW(4), .DW_CTRL(4), .NUM_IN(NUM_IN)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .line_cnt (line_cnt)
    );

    int tests_run = 0;
    int fails     = 0;
    bit bypass    = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  m_row[$];
    logic [7:0]  m_data[$];
    bit          m_last[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] build_line();
        logic [31:0] l;
        logic [3:0]  ctrl;
        l = '0;
        for (int i = 0; i < m_data.size(); i++) begin
            ctrl = 4'b1000;
            if (i + 1 < m_data.size() && m_row[i] == m_row[i+1]) ctrl[2] = 1'b1;
            if (m_last[i]) ctrl[1] = 1'b1;
            l[i*16 +: 16] = {ctrl, m_row[i], m_data[i]};
        end
        return l;
    endfunction

    task automatic model_accept(input logic [3:0] row, input logic [7:0] data, input bit last);
        m_row.push_back(row);
        m_data.push_back(data);
        m_last.push_back(last);
        if (last || m_data.size() == NUM_IN) begin
            exp_q.push_back(build_line());
            m_row.delete();
            m_data.delete();
            m_last.delete();
        end
    endtask

    // scoreboard: every consumed line must match the oldest expected line
    always @(negedge clk) begin
        if (rst && !bypass && bus.out_valid && bus.out_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_line got=%h required=none", bus.out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.out !== e) begin
                    fails++;
                    $display("FAIL line_data got=%h required=%h", bus.out, e);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_row    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        exp_q.delete();
        m_row.delete();
        m_data.delete();
        m_last.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [3:0] row, input logic [7:0] data, input bit last);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        bus.in_data  = data;
        bus.in_last  = last;
        while (!acc && n < BUDGET) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(row, data, last);
                acc = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tests_run++;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout got=not_accepted required=accepted row=%0d data=%h", row, data);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || bus.out_valid) begin
            fails++;
            $display("FAIL %s_drain got=pending(%0d) required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_row    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests_run += 4;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
        if (bus.out !== 32'h0) begin fails++; $display("FAIL reset_out got=%h required=00000000", bus.out); end
        if (line_cnt !== 16'h0) begin fails++; $display("FAIL reset_line_cnt got=%h required=0000", line_cnt); end
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
        do_reset();
    endtask

    task automatic test_full_line();
        do_reset();
        send(4'd0, 8'h01, 1'b0);
        send(4'd0, 8'h02, 1'b0);
        @(negedge clk);
        tests_run += 2;
        if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL full_line_valid got=%b required=1", bus.out_valid); end
        if (bus.out !== 32'h8002C001) begin fails++; $display("FAIL full_line_out got=%h required=8002c001", bus.out); end
        @(posedge clk); #1;
        wait_drain("full_line");
    endtask

    task automatic test_last_split();
        do_reset();
        send(4'd0, 8'h01, 1'b0);
        send(4'd1, 8'h02, 1'b1);
        @(negedge clk);
        tests_run++;
        if (bus.out !== 32'hA1028001) begin fails++; $display("FAIL last_split_out got=%h required=a1028001", bus.out); end
        @(posedge clk); #1;
        send(4'd3, 8'h11, 1'b0);
        send(4'd3, 8'h22, 1'b1);
        @(negedge clk);
        tests_run++;
        if (bus.out !== 32'hA322C311) begin fails++; $display("FAIL last_full_out got=%h required=a322c311", bus.out); end
        @(posedge clk); #1;
        wait_drain("last_split");
    endtask

    task automatic test_single_last();
        do_reset();
        send(4'd0, 8'h05, 1'b1);
        @(negedge clk);
        tests_run++;
        if (bus.out !== 32'h0000A005) begin fails++; $display("FAIL single_out got=%h required=0000a005", bus.out); end
        @(posedge clk); #1;
        wait_drain("single");
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_extra got=%b required=0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b0;
        send(4'd0, 8'h01, 1'b0);
        send(4'd0, 8'h02, 1'b0);
        send(4'd1, 8'h03, 1'b0);
        repeat (3) begin
            @(negedge clk);
            tests_run += 2;
            if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b required=0", bus.in_ready); end
            if (bus.out !== 32'h8002C001) begin fails++; $display("FAIL bp_hold got=%h required=8002c001", bus.out); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(4'd1, 8'h04, 1'b0);
        wait_drain("bp");
        tests_run++;
        if (line_cnt !== 16'd2) begin fails++; $display("FAIL bp_line_cnt got=%0d required=2", line_cnt); end
    endtask

    task automatic test_last_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        send(4'd1, 8'h10, 1'b0);
        send(4'd1, 8'h20, 1'b0);
        send(4'd2, 8'h30, 1'b1);
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL lbp_in_ready got=%b required=0", bus.in_ready); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain("lbp");
        tests_run++;
        if (line_cnt !== 16'd2) begin fails++; $display("FAIL lbp_line_cnt got=%0d required=2", line_cnt); end
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        bus.out_ready = 1'b0;
        send(4'd0, 8'h01, 1'b0);
        send(4'd0, 8'h02, 1'b0);
        send(4'd1, 8'h03, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        m_row.delete();
        m_data.delete();
        m_last.delete();
        @(negedge clk);
        tests_run += 4;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%b required=0", bus.out_valid); end
        if (bus.out !== 32'h0) begin fails++; $display("FAIL mid_out got=%h required=00000000", bus.out); end
        if (line_cnt !== 16'h0) begin fails++; $display("FAIL mid_line_cnt got=%h required=0000", line_cnt); end
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b required=1", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        send(4'd2, 8'h04, 1'b0);
        send(4'd2, 8'h05, 1'b0);
        @(negedge clk);
        tests_run++;
        if (bus.out !== 32'h8205C204) begin fails++; $display("FAIL mid_fresh got=%h required=8205c204", bus.out); end
        @(posedge clk); #1;
        wait_drain("mid");
        tests_run++;
        if (line_cnt !== 16'd1) begin fails++; $display("FAIL mid_cnt got=%0d required=1", line_cnt); end
    endtask

    task automatic test_line_cnt_wrap();
        int n;
        do_reset();
        bypass = 1;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_row   = 4'd7;
        bus.in_data  = 8'h77;
        repeat (65535) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n = 0;
        while (bus.out_valid && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        bypass = 0;
        @(negedge clk);
        tests_run++;
        if (line_cnt !== 16'hFFFF) begin fails++; $display("FAIL wrap_pre got=%h required=ffff", line_cnt); end
        @(posedge clk); #1;
        send(4'd2, 8'h09, 1'b1);
        wait_drain("wrap");
        tests_run++;
        if (line_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_cnt got=%h required=0000", line_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_last_split();
        test_single_last();
        test_back_to_back();
        test_last_backpressure();
        test_reset_mid_line();
        test_line_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
